// File: rtl/form_error_checker.sv
// Form-error checker for the fixed-form fields of a CAN frame: CRC/ACK delimiters, EOF and
// error/overload delimiters. Define FORM_ERR_STICKY_EN to hold the first error until reset.
module form_error_checker #(
  parameter int unsigned EOF_LEN   = 7,
  parameter int unsigned DELIM_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             SP,
  input  logic             reset,
  input  logic             RX,
  input  logic             F_CRC_D,
  input  logic             F_ACK_D,
  input  logic             F_EOF,
  input  logic             F_DELIM,
  output logic             FORM_Error,
  output logic [2:0]       FORM_Code,
  output logic             Overload_Req,
  output logic             Busy,
  output logic [CNT_W-1:0] Bit_Idx
);

  typedef enum logic [1:0] {StIdle, StEofChk, StDlChk} state_e;

  localparam logic [CNT_W-1:0] EofLast = CNT_W'(EOF_LEN - 1);
  localparam logic [CNT_W-1:0] DlLast  = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] IdxMax  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, idx_cur, idx_inc;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             ovl_q, ovl_d;
  logic             busy_q;

  logic crc_err, ack_err, eof_err, dl_err, in_eof, in_dl, eof_last, dl_last, new_err;
  logic [2:0] new_code;

  always_comb begin
    crc_err = F_CRC_D & ~RX;
    ack_err = F_ACK_D & ~RX;

    // A new field flag restarts the check; the old field's bit is not evaluated.
    in_eof  = 1'b0;
    in_dl   = 1'b0;
    idx_cur = idx_q;
    if (F_EOF) begin
      in_eof  = 1'b1;
      idx_cur = '0;
    end else if (F_DELIM) begin
      in_dl   = 1'b1;
      idx_cur = '0;
    end else if (state_q == StEofChk) begin
      in_eof = 1'b1;
    end else if (state_q == StDlChk) begin
      in_dl = 1'b1;
    end

    eof_last = in_eof && (idx_cur == EofLast);
    dl_last  = in_dl && (idx_cur == DlLast);
    eof_err  = in_eof & ~RX & ~eof_last;
    dl_err   = in_dl & ~RX;
    ovl_d    = in_eof & ~RX & eof_last;
    idx_inc  = (idx_cur == IdxMax) ? idx_cur : idx_cur + CNT_W'(1);

    // Any dominant bit inside a field ends it (error or overload), as does its last bit.
    state_d = StIdle;
    idx_d   = '0;
    if (RX && !eof_last && !dl_last) begin
      if (in_eof) begin
        state_d = StEofChk;
        idx_d   = idx_inc;
      end else if (in_dl) begin
        state_d = StDlChk;
        idx_d   = idx_inc;
      end
    end

    new_err = crc_err | ack_err | eof_err | dl_err;
    if (crc_err)      new_code = 3'd1;
    else if (ack_err) new_code = 3'd2;
    else if (eof_err) new_code = 3'd3;
    else if (dl_err)  new_code = 3'd4;
    else              new_code = 3'd0;

`ifdef FORM_ERR_STICKY_EN
    err_d  = err_q | new_err;
    code_d = err_q ? code_q : new_code;
`else
    err_d  = new_err;
    code_d = new_code;
`endif
  end

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      ovl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovl_q   <= ovl_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign FORM_Error   = err_q;
  assign FORM_Code    = code_q;
  assign Overload_Req = ovl_q;
  assign Busy         = busy_q;
  assign Bit_Idx      = idx_q;

endmodule

// File: tb/tb_form_error_checker.sv
// Directed bench for form_error_checker with EOF_LEN=7, DELIM_LEN=8, CNT_W=4.
module tb_form_error_checker;

  logic       SP = 1'b0;
  logic       reset = 1'b0;
  logic       RX = 1'b1, F_CRC_D = 1'b0, F_ACK_D = 1'b0, F_EOF = 1'b0, F_DELIM = 1'b0;
  logic       FORM_Error, Overload_Req, Busy;
  logic [2:0] FORM_Code;
  logic [3:0] Bit_Idx;
  int         checks = 0;
  int         errors = 0;

  form_error_checker #(.EOF_LEN(7), .DELIM_LEN(8), .CNT_W(4)) dut (
    .SP(SP), .reset(reset), .RX(RX), .F_CRC_D(F_CRC_D), .F_ACK_D(F_ACK_D), .F_EOF(F_EOF),
    .F_DELIM(F_DELIM), .FORM_Error(FORM_Error), .FORM_Code(FORM_Code),
    .Overload_Req(Overload_Req), .Busy(Busy), .Bit_Idx(Bit_Idx)
  );

  always #5 SP = ~SP;

  // Packed view {err, code, ovl, busy, idx}
  function automatic logic [9:0] obs();
    return {FORM_Error, FORM_Code, Overload_Req, Busy, Bit_Idx};
  endfunction

  function automatic logic [9:0] ev(input logic e, input logic [2:0] c, input logic o,
                                    input logic b, input logic [3:0] i);
    return {e, c, o, b, i};
  endfunction

  // Drive one bit time, then sample 1 ns after the sample-point edge.
  task automatic step(input logic rx, input logic crc = 0, input logic ack = 0,
                      input logic eof = 0, input logic dl = 0);
    @(negedge SP);
    RX = rx; F_CRC_D = crc; F_ACK_D = ack; F_EOF = eof; F_DELIM = dl;
    @(posedge SP);
    #1;
  endtask

  task automatic test_reset();
    RX = 1'b0; F_CRC_D = 1'b1;
    @(posedge SP); #1;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
    @(negedge SP);
    RX = 1'b1; F_CRC_D = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single_bit();
    logic [9:0] exp_v [4];
    exp_v[0] = ev(1, 1, 0, 0, 0); exp_v[1] = ev(0, 0, 0, 0, 0);
    exp_v[2] = ev(1, 2, 0, 0, 0); exp_v[3] = ev(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: step(.rx(0), .crc(1));
        1: step(.rx(1), .ack(1));
        2: step(.rx(0), .ack(1));
        default: step(.rx(1));
      endcase
      checks++;
      if (obs() !== exp_v[k]) begin
        errors++;
        $display("FAIL single_bit[%0d]: got %b want %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_eof_ok();
    step(.rx(1), .eof(1));
    checks++;
    if (obs() !== ev(0, 0, 0, 1, 1)) begin
      errors++;
      $display("FAIL eof_ok[1]: got %b want %b", obs(), ev(0, 0, 0, 1, 1));
    end
    for (int k = 2; k <= 7; k++) begin
      step(.rx(1));
      checks++;
      if (obs() !== ((k < 7) ? ev(0, 0, 0, 1, 4'(k)) : ev(0, 0, 0, 0, 0))) begin
        errors++;
        $display("FAIL eof_ok[%0d]: got %b want %b", k, obs(),
                 (k < 7) ? ev(0, 0, 0, 1, 4'(k)) : ev(0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_eof_err();
    step(.rx(1), .eof(1));
    step(.rx(1));
    step(.rx(1));
    step(.rx(0));
    checks++;
    if (obs() !== ev(1, 3, 0, 0, 0)) begin
      errors++;
      $display("FAIL eof_err_bit4: got %b want %b", obs(), ev(1, 3, 0, 0, 0));
    end
    step(.rx(0));  // back in idle: a dominant bit is not a form error
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL eof_err_after: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_eof_last();
    step(.rx(1), .eof(1));
    for (int k = 2; k <= 6; k++) step(.rx(1));
    checks++;
    if (obs() !== ev(0, 0, 0, 1, 6)) begin
      errors++;
      $display("FAIL eof_last_pre: got %b want %b", obs(), ev(0, 0, 0, 1, 6));
    end
    step(.rx(0));
    checks++;
    if (obs() !== ev(0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL eof_last_ovl: got %b want %b", obs(), ev(0, 0, 1, 0, 0));
    end
    step(.rx(1));
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL eof_last_pulse: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_delim();
    step(.rx(1), .dl(1));
    for (int k = 2; k <= 7; k++) begin
      step(.rx(1));
      checks++;
      if (obs() !== ev(0, 0, 0, 1, 4'(k))) begin
        errors++;
        $display("FAIL delim[%0d]: got %b want %b", k, obs(), ev(0, 0, 0, 1, 4'(k)));
      end
    end
    step(.rx(0));
    checks++;
    if (obs() !== ev(1, 4, 0, 0, 0)) begin
      errors++;
      $display("FAIL delim_bit8: got %b want %b", obs(), ev(1, 4, 0, 0, 0));
    end
    step(.rx(0), .crc(1), .ack(1));
    checks++;
    if (obs() !== ev(1, 1, 0, 0, 0)) begin
      errors++;
      $display("FAIL crc_over_ack: got %b want %b", obs(), ev(1, 1, 0, 0, 0));
    end
    step(.rx(0), .dl(1));
    checks++;
    if (obs() !== ev(1, 4, 0, 0, 0)) begin
      errors++;
      $display("FAIL delim_bit1: got %b want %b", obs(), ev(1, 4, 0, 0, 0));
    end
  endtask

  task automatic test_restart();
    step(.rx(1), .eof(1));
    step(.rx(1));
    step(.rx(1), .dl(1));
    checks++;
    if (obs() !== ev(0, 0, 0, 1, 1)) begin
      errors++;
      $display("FAIL restart_dl: got %b want %b", obs(), ev(0, 0, 0, 1, 1));
    end
    step(.rx(1));
    step(.rx(1), .eof(1), .dl(1));
    checks++;
    if (obs() !== ev(0, 0, 0, 1, 1)) begin
      errors++;
      $display("FAIL restart_both: got %b want %b", obs(), ev(0, 0, 0, 1, 1));
    end
    for (int k = 2; k <= 6; k++) step(.rx(1));
    step(.rx(0));  // only an EOF field treats bit 7 as the overload exception
    checks++;
    if (obs() !== ev(0, 0, 1, 0, 0)) begin
      errors++;
      $display("FAIL restart_eof_wins: got %b want %b", obs(), ev(0, 0, 1, 0, 0));
    end
  endtask

  task automatic test_abort_and_priority();
    step(.rx(1), .eof(1));
    step(.rx(0), .ack(1));
    checks++;
    if (obs() !== ev(1, 2, 0, 0, 0)) begin
      errors++;
      $display("FAIL ack_in_eof: got %b want %b", obs(), ev(1, 2, 0, 0, 0));
    end
    step(.rx(0));
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL abort_idle: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
    step(.rx(0), .eof(1), .dl(1));
    checks++;
    if (obs() !== ev(1, 3, 0, 0, 0)) begin
      errors++;
      $display("FAIL eof_over_dl: got %b want %b", obs(), ev(1, 3, 0, 0, 0));
    end
    step(.rx(0), .ack(1), .eof(1), .dl(1));
    checks++;
    if (obs() !== ev(1, 2, 0, 0, 0)) begin
      errors++;
      $display("FAIL ack_over_eof: got %b want %b", obs(), ev(1, 2, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    step(.rx(1), .eof(1));
    step(.rx(1));
    step(.rx(1));
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_async: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
    @(negedge SP);
    reset = 1'b1;
    step(.rx(0));
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_abandon: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
  endtask

`ifdef FORM_ERR_STICKY_EN
  task automatic test_sticky();
    step(.rx(0), .ack(1));
    for (int k = 0; k < 3; k++) step(.rx(1));
    step(.rx(0), .crc(1));
    checks++;
    if (obs() !== ev(1, 2, 0, 0, 0)) begin
      errors++;
      $display("FAIL sticky_hold: got %b want %b", obs(), ev(1, 2, 0, 0, 0));
    end
    step(.rx(1), .eof(1));
    checks++;
    if (obs() !== ev(1, 2, 0, 1, 1)) begin
      errors++;
      $display("FAIL sticky_field: got %b want %b", obs(), ev(1, 2, 0, 1, 1));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== ev(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL sticky_reset: got %b want %b", obs(), ev(0, 0, 0, 0, 0));
    end
    @(negedge SP);
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
`ifdef FORM_ERR_STICKY_EN
    test_sticky();
`else
    test_single_bit();
    test_eof_ok();
    test_eof_err();
    test_eof_last();
    test_delim();
    test_restart();
    test_abort_and_priority();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
